// File: rtl/mem_responder.sv
// mem_responder: memory-side responder arbitrating the fetch and LSU request/grant ports
//
// Accepts one request at a time (data port has fixed priority), waits LATENCY
// cycles after the grant, performs the array access and returns a one-cycle
// response on the port that issued the request.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   instr_req_ip/addr_ip    fetch request (read-only), held until granted
//   instr_gnt_op            fetch request accepted this cycle (combinational)
//   instr_rvalid_op/rdata_op fetch response pulse and fetched word
//   data_req_ip/we_ip/size_ip/addr_ip/wdata_ip  LSU request, held until granted
//   data_gnt_op             LSU request accepted this cycle (combinational)
//   data_rvalid_op/rdata_op LSU response pulse and loaded word (0 for stores)
//   err_op                  error flag, pulses together with either rvalid
//
// Build option: define WRITE_PROTECT_EN to reject stores below DATA_START_WORD.
module mem_responder #(
    parameter int unsigned DEPTH           = 256,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned DATA_START_WORD = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_req_ip,
    input  logic [31:0] instr_addr_ip,
    output logic        instr_gnt_op,
    output logic        instr_rvalid_op,
    output logic [31:0] instr_rdata_op,
    input  logic        data_req_ip,
    input  logic        data_we_ip,
    input  logic [1:0]  data_size_ip,
    input  logic [31:0] data_addr_ip,
    input  logic [31:0] data_wdata_ip,
    output logic        data_gnt_op,
    output logic        data_rvalid_op,
    output logic [31:0] data_rdata_op,
    output logic        err_op
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

`ifdef WRITE_PROTECT_EN
    localparam logic WP_EN = 1'b1;
`else
    localparam logic WP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam state_t AFTER_GNT = (LATENCY == 1) ? RESP : WAIT;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        instr_rvalid_q, instr_rvalid_d;
    logic        data_rvalid_q, data_rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [DEPTH];

    logic        any_gnt;
    logic        enter_resp;
    logic        acc_port;
    logic        acc_we;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [29:0] word_idx;
    logic [AW-1:0] idx;
    logic        out_of_range;
    logic        misaligned;
    logic        protect;
    logic        acc_err;
    logic [3:0]  strb;
    logic        wr_en;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_gnt ? AFTER_GNT : IDLE;
            WAIT:    state_d = (cnt_q == 4'd1) ? RESP : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: grants are only offered in IDLE and never during reset
    always_comb begin
        data_gnt_op  = reset && (state_q == IDLE) && data_req_ip;
        instr_gnt_op = reset && (state_q == IDLE) && instr_req_ip && !data_req_ip;
        any_gnt      = data_gnt_op || instr_gnt_op;
    end

    // The transaction being serviced: live inputs while IDLE (so LATENCY==1
    // can complete on the granting edge), the latched copy afterwards.
    always_comb begin
        acc_port  = (state_q == IDLE) ? data_req_ip : port_q;
        acc_we    = (state_q == IDLE) ? (data_req_ip && data_we_ip) : we_q;
        acc_size  = (state_q == IDLE) ? (data_req_ip ? data_size_ip : 2'b10) : size_q;
        acc_addr  = (state_q == IDLE) ? (data_req_ip ? data_addr_ip : instr_addr_ip) : addr_q;
        acc_wdata = (state_q == IDLE) ? data_wdata_ip : wdata_q;
        port_d    = acc_port;
        we_d      = acc_we;
        size_d    = acc_size;
        addr_d    = acc_addr;
        wdata_d   = acc_wdata;
        cnt_d     = (state_q == IDLE) ? CNT_INIT : (state_q == WAIT) ? cnt_q - 4'd1 : cnt_q;
    end

    // Address checks and byte-lane selection for the access at RESP entry
    always_comb begin
        enter_resp   = (state_d == RESP) && (state_q != RESP);
        word_idx     = acc_addr[31:2];
        idx          = acc_addr[AW+1:2];
        out_of_range = {2'b00, word_idx} >= DEPTH;
        // Size 2'b11 is not a legal LSU size and is rejected like a misalignment
        misaligned   = (acc_size == 2'b11) ||
                       (acc_size == 2'b10 && acc_addr[1:0] != 2'b00) ||
                       (acc_size == 2'b01 && acc_addr[0]);
        protect      = WP_EN && acc_we && ({2'b00, word_idx} < DATA_START_WORD);
        acc_err      = out_of_range || misaligned || protect;
        strb         = (acc_size == 2'b00) ? (4'b0001 << acc_addr[1:0]) :
                       (acc_size == 2'b01) ? (acc_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wr_en        = enter_resp && acc_we && !acc_err;
        instr_rvalid_d = enter_resp && !acc_port;
        data_rvalid_d  = enter_resp && acc_port;
        err_d          = enter_resp && acc_err;
        rdata_d        = (enter_resp && !acc_we && !acc_err) ? mem[idx] : 32'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q          <= 4'd0;
            port_q         <= 1'b0;
            we_q           <= 1'b0;
            size_q         <= 2'b00;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            err_q          <= 1'b0;
            rdata_q        <= 32'd0;
        end else begin
            cnt_q          <= cnt_d;
            port_q         <= port_d;
            we_q           <= we_d;
            size_q         <= size_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            instr_rvalid_q <= instr_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
            err_q          <= err_d;
            rdata_q        <= rdata_d;
        end
    end

    // Array is intentionally not reset; stores touch only their byte lanes
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    assign instr_rvalid_op = instr_rvalid_q;
    assign data_rvalid_op  = data_rvalid_q;
    assign instr_rdata_op  = instr_rvalid_q ? rdata_q : 32'd0;
    assign data_rdata_op   = data_rvalid_q ? rdata_q : 32'd0;
    assign err_op          = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with a transaction-level reference model
module tb_mem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int DSW   = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_req_ip = 1'b0;
    logic [31:0] instr_addr_ip = 32'd0;
    logic        instr_gnt_op;
    logic        instr_rvalid_op;
    logic [31:0] instr_rdata_op;
    logic        data_req_ip = 1'b0;
    logic        data_we_ip = 1'b0;
    logic [1:0]  data_size_ip = 2'b10;
    logic [31:0] data_addr_ip = 32'd0;
    logic [31:0] data_wdata_ip = 32'd0;
    logic        data_gnt_op;
    logic        data_rvalid_op;
    logic [31:0] data_rdata_op;
    logic        err_op;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .DATA_START_WORD(DSW)) dut (
        .clock(clock), .reset(reset),
        .instr_req_ip(instr_req_ip), .instr_addr_ip(instr_addr_ip),
        .instr_gnt_op(instr_gnt_op), .instr_rvalid_op(instr_rvalid_op), .instr_rdata_op(instr_rdata_op),
        .data_req_ip(data_req_ip), .data_we_ip(data_we_ip), .data_size_ip(data_size_ip),
        .data_addr_ip(data_addr_ip), .data_wdata_ip(data_wdata_ip),
        .data_gnt_op(data_gnt_op), .data_rvalid_op(data_rvalid_op), .data_rdata_op(data_rdata_op),
        .err_op(err_op)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: no event within bound (cycle %0d)", nm, cyc);
    endtask

    // Reference model: one outstanding transaction, serviced LAT cycles after
    // its grant, with the port free again LAT+1 cycles after the grant.
    logic [31:0] mem_m [DEPTH];
    bit          known [DEPTH];
    bit          p_v = 0;
    int          p_due;
    bit          p_port, p_we;
    logic [1:0]  p_size;
    logic [31:0] p_addr, p_wdata;
    int          free_at = 0;

    initial for (int i = 0; i < DEPTH; i++) known[i] = 0;

    always @(negedge clock) begin
        bit e_ig, e_dg, e_iv, e_dv, e_er, chk_rd;
        logic [31:0] e_ir, e_dr, rd;
        int widx, nb, off;
        e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_er = 0; e_ir = 0; e_dr = 0; chk_rd = 1;
        if (!reset) begin
            p_v = 0;
            free_at = cyc;
        end else begin
            if (p_v && p_due == cyc) begin
                widx = int'(p_addr >> 2);
                e_er = (widx >= DEPTH);
                if (p_port)
                    e_er = e_er || p_size == 2'b11 || (p_size == 2'b01 && p_addr[0]) ||
                           (p_size == 2'b10 && p_addr[1:0] != 2'b00);
                else
                    e_er = e_er || p_addr[1:0] != 2'b00;
`ifdef WRITE_PROTECT_EN
                if (p_we && widx < DSW) e_er = 1;
`endif
                rd = 0;
                if (!e_er) begin
                    if (p_we) begin
                        nb = 1 << p_size;
                        for (int k = 0; k < nb; k++) begin
                            off = int'(p_addr[1:0]) + k;
                            mem_m[widx][8*off +: 8] = p_wdata[8*off +: 8];
                        end
                        if (nb == 4) known[widx] = 1;
                    end else begin
                        rd = mem_m[widx];
                        chk_rd = known[widx];
                    end
                end
                if (p_port) begin e_dv = 1; e_dr = rd; end
                else begin e_iv = 1; e_ir = rd; end
                p_v = 0;
            end
            if (cyc >= free_at) begin
                e_dg = data_req_ip;
                e_ig = instr_req_ip && !data_req_ip;
                if (e_dg || e_ig) begin
                    p_v = 1; p_due = cyc + LAT; p_port = e_dg; p_we = e_dg && data_we_ip;
                    p_size = e_dg ? data_size_ip : 2'b10;
                    p_addr = e_dg ? data_addr_ip : instr_addr_ip;
                    p_wdata = data_wdata_ip;
                    free_at = cyc + LAT + 1;
                end
            end
        end
        chk("m_instr_gnt", 32'(instr_gnt_op), 32'(e_ig));
        chk("m_data_gnt", 32'(data_gnt_op), 32'(e_dg));
        chk("m_instr_rvalid", 32'(instr_rvalid_op), 32'(e_iv));
        chk("m_data_rvalid", 32'(data_rvalid_op), 32'(e_dv));
        chk("m_err", 32'(err_op), 32'(e_er));
        if (chk_rd) begin
            chk("m_instr_rdata", instr_rdata_op, e_ir);
            chk("m_data_rdata", data_rdata_op, e_dr);
        end
    end

    task automatic dx(input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output bit er, output int glat, output int rlat);
        int t0, tg;
        bit got;
        rd = 0; er = 0; glat = -1; rlat = -1; tg = 0;
        @(posedge clock); #1;
        data_req_ip = 1; data_we_ip = we; data_size_ip = sz; data_addr_ip = a; data_wdata_ip = wd;
        t0 = cyc; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (data_gnt_op) begin got = 1; tg = cyc; glat = cyc - t0; end
        end
        @(posedge clock); #1;
        data_req_ip = 0; data_we_ip = 0;
        if (!got) begin timeout("data_gnt"); return; end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (data_rvalid_op) begin got = 1; rlat = cyc - tg; rd = data_rdata_op; er = err_op; end
        end
        if (!got) timeout("data_rvalid");
    endtask

    logic [31:0] rd, v1;
    bit          er;
    int          gl, rl;
    int          t0, dg, ig, dv, iv, dvn, ivn;

    initial begin
        data_req_ip = 1; instr_req_ip = 1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_gnt_forced0", 32'({instr_gnt_op, data_gnt_op}), 32'd0);
        chk("rst_outs", 32'({instr_rvalid_op, data_rvalid_op, err_op}), 32'd0);
        @(posedge clock); #1;
        data_req_ip = 0; instr_req_ip = 0;
        @(posedge clock); #1;
        reset = 1;

        dx(1, 2'b10, 32'h200, 32'hDEADBEEF, rd, er, gl, rl);
        chk("st_word_gnt_lat", gl, 0);
        chk("st_word_rsp_lat", rl, 2);
        chk("st_word_err", 32'(er), 0);
        chk("st_word_rdata", rd, 0);
        dx(0, 2'b10, 32'h200, 0, rd, er, gl, rl);
        chk("ld_deadbeef", rd, 32'hDEADBEEF);

        dx(1, 2'b10, 32'h200, 32'h11223344, rd, er, gl, rl);
        dx(1, 2'b00, 32'h201, 32'h0000AB00, rd, er, gl, rl);
        dx(0, 2'b00, 32'h200, 0, rd, er, gl, rl);
        chk("ld_after_byte", rd, 32'h1122AB44);
        dx(1, 2'b01, 32'h202, 32'h55660000, rd, er, gl, rl);
        dx(0, 2'b01, 32'h200, 0, rd, er, gl, rl);
        chk("ld_after_half", rd, 32'h5566AB44);

        dx(0, 2'b10, 32'h202, 0, rd, er, gl, rl);
        chk("misal_word_err", 32'(er), 1);
        chk("misal_word_rdata", rd, 0);
        dx(0, 2'b10, 32'(4 * DEPTH), 0, rd, er, gl, rl);
        chk("oor_err", 32'(er), 1);
        dx(1, 2'b01, 32'h203, 32'hFFFFFFFF, rd, er, gl, rl);
        chk("misal_half_st_err", 32'(er), 1);
        dx(1, 2'b10, 32'(4 * DEPTH), 32'hFFFFFFFF, rd, er, gl, rl);
        chk("oor_st_err", 32'(er), 1);
        dx(0, 2'b00, 32'h203, 0, rd, er, gl, rl);
        chk("unchanged_after_errs", rd, 32'h5566AB44);
        chk("byte_ld_odd_err", 32'(er), 0);

        dx(1, 2'b10, 32'hA0, 32'h13579BDF, rd, er, gl, rl);
        @(posedge clock); #1;
        instr_req_ip = 1; instr_addr_ip = 32'hA0;
        data_req_ip = 1; data_we_ip = 0; data_size_ip = 2'b10; data_addr_ip = 32'h200;
        t0 = cyc; dg = -1; ig = -1; dv = -1; iv = -1; dvn = 0; ivn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (data_gnt_op) dg = cyc - t0;
            if (instr_gnt_op) ig = cyc - t0;
            if (data_rvalid_op) begin dv = cyc - t0; dvn++; end
            if (instr_rvalid_op) begin
                iv = cyc - t0; ivn++;
                chk("sim_instr_rdata", instr_rdata_op, 32'h13579BDF);
                chk("sim_instr_data_rdata0", data_rdata_op, 0);
            end
            @(posedge clock); #1;
            if (dg >= 0) data_req_ip = 0;
            if (ig >= 0) instr_req_ip = 0;
        end
        chk("sim_data_gnt_cyc", dg, 0);
        chk("sim_data_rvalid_cyc", dv, 2);
        chk("sim_instr_gnt_cyc", ig, 3);
        chk("sim_instr_rvalid_cyc", iv, 5);
        chk("sim_rvalid_counts", 32'({dvn[7:0], ivn[7:0]}), 32'h0101);

        @(posedge clock); #1;
        instr_req_ip = 1; instr_addr_ip = 32'hA2;
        t0 = cyc; iv = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (instr_gnt_op) begin @(posedge clock); #1; instr_req_ip = 0; end
            if (instr_rvalid_op && iv < 0) begin iv = cyc - t0; chk("instr_misal_err", 32'(err_op), 1); end
        end
        instr_req_ip = 0;
        chk("instr_misal_rsp_cyc", iv, 2);

        dx(1, 2'b10, 32'h300, 32'hCAFEF00D, rd, er, gl, rl);
        @(posedge clock); #1;
        data_req_ip = 1; data_we_ip = 1; data_size_ip = 2'b10; data_addr_ip = 32'h300; data_wdata_ip = 32'h0BADBEEF;
        @(negedge clock);
        chk("rst_wait_pre_gnt", 32'(data_gnt_op), 1);
        @(posedge clock); #1;
        data_req_ip = 0; data_we_ip = 0; reset = 0;
        @(negedge clock);
        chk("rst_wait_flags", 32'({instr_gnt_op, instr_rvalid_op, data_gnt_op, data_rvalid_op, err_op}), 0);
        chk("rst_wait_rdata", instr_rdata_op | data_rdata_op, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1;
        dx(0, 2'b10, 32'h300, 0, rd, er, gl, rl);
        chk("rst_word_unchanged", rd, 32'hCAFEF00D);
        chk("rst_regrant_lat", gl, 0);

`ifdef WRITE_PROTECT_EN
        dx(0, 2'b10, 32'h40, 0, v1, er, gl, rl);
        dx(1, 2'b10, 32'h40, 32'h12345678, rd, er, gl, rl);
        chk("wp_st_err", 32'(er), 1);
        dx(0, 2'b10, 32'h40, 0, rd, er, gl, rl);
        chk("wp_word_unchanged", rd, v1);
`else
        dx(1, 2'b10, 32'h40, 32'h12345678, rd, er, gl, rl);
        chk("nowp_st_err", 32'(er), 0);
        dx(0, 2'b10, 32'h40, 0, rd, er, gl, rl);
        chk("nowp_ld", rd, 32'h12345678);
`endif

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
